// File: rtl/wb_trace_monitor.sv
// Retirement-trace monitor: stamps regfile/dmem writes and queues them in a FIFO.
// Optional macro TRACE_PC_EN adds a per-entry copy of the fetch PC.
module wb_trace_monitor #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 16,
    parameter int CYCLE_LIMIT = 50,
    parameter int STAMP_W     = 16,
    parameter int WRAP        = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              pc,
    input  logic                     ctrl_writeEnable,
    input  logic [4:0]               ctrl_writeReg,
    input  logic [DATA_W-1:0]        data_writeReg,
    input  logic                     wren,
    input  logic [11:0]              address_dmem,
    input  logic [DATA_W-1:0]        data,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic                     rd_kind,
    output logic [11:0]              rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic [STAMP_W-1:0]       rd_stamp,
    output logic [31:0]              rd_pc,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     done,
    output logic                     overflow
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CL_W  = $clog2(CYCLE_LIMIT + 1);
    localparam int CNT_W = (STAMP_W > CL_W) ? STAMP_W : CL_W;

    typedef enum logic {ST_CAPTURE, ST_DONE} state_t;
    state_t state_q, state_d;

    logic [CNT_W-1:0] cyc;
    logic [AW-1:0]    wr_ptr, rd_ptr, wr_nxt;

    logic                mem_kind  [DEPTH];
    logic [11:0]         mem_addr  [DEPTH];
    logic [DATA_W-1:0]   mem_data  [DEPTH];
    logic [STAMP_W-1:0]  mem_stamp [DEPTH];

    logic          capturing, pop, reg_ev, mem_ev, any_ev, both, have0, have1;
    logic          push0, push1, drop;
    logic [1:0]    n_push, ovw;
    logic [AW+1:0] free;
    logic          kind0;
    logic [11:0]   addr0;
    logic [DATA_W-1:0] data0;

    always_comb begin
        state_d   = state_q;
        capturing = (state_q == ST_CAPTURE);
        done      = (state_q == ST_DONE);
        if (capturing && cyc == CNT_W'(CYCLE_LIMIT - 1))
            state_d = ST_DONE;
    end

    // Free space counts a same-cycle pop, so push+pop at full never drops.
    always_comb begin
        pop    = (count != '0) && rd_ready;
        reg_ev = capturing && ctrl_writeEnable && (ctrl_writeReg != '0);
        mem_ev = capturing && wren;
        any_ev = reg_ev | mem_ev;
        both   = reg_ev & mem_ev;
        free   = (AW+2)'(DEPTH) - (AW+2)'(count) + (AW+2)'(pop);
        have0  = (free != '0);
        have1  = (free > (AW+2)'(1));
        push0  = 1'b0;
        push1  = 1'b0;
        drop   = 1'b0;
        ovw    = 2'd0;
        if (WRAP != 0) begin
            push0 = any_ev;
            push1 = both;
        end else begin
            push0 = any_ev && have0;
            push1 = both && have1;
            drop  = (any_ev && !have0) || (both && !have1);
        end
        n_push = {1'b0, push0} + {1'b0, push1};
        if (WRAP != 0) begin
            if (!have0)
                ovw = n_push;
            else if (!have1 && both)
                ovw = 2'd1;
        end
        wr_nxt = wr_ptr + AW'(1);
        kind0  = !reg_ev;
        addr0  = reg_ev ? {7'b0, ctrl_writeReg} : address_dmem;
        data0  = reg_ev ? data_writeReg : data;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_CAPTURE;
            cyc      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capturing)
                cyc <= cyc + CNT_W'(1);
            wr_ptr <= wr_ptr + AW'(n_push);
            rd_ptr <= rd_ptr + AW'(pop) + AW'(ovw);
            count  <= count + (AW+1)'(n_push) - (AW+1)'(pop) - (AW+1)'(ovw);
            if (drop || ovw != 2'd0)
                overflow <= 1'b1;
        end
    end

    // A dual event puts the reg entry first; the second slot is always the mem write.
    always_ff @(posedge clock) begin
        if (push0) begin
            mem_kind[wr_ptr]  <= kind0;
            mem_addr[wr_ptr]  <= addr0;
            mem_data[wr_ptr]  <= data0;
            mem_stamp[wr_ptr] <= cyc[STAMP_W-1:0];
        end
        if (push1) begin
            mem_kind[wr_nxt]  <= 1'b1;
            mem_addr[wr_nxt]  <= address_dmem;
            mem_data[wr_nxt]  <= data;
            mem_stamp[wr_nxt] <= cyc[STAMP_W-1:0];
        end
    end

`ifdef TRACE_PC_EN
    logic [31:0] mem_pc [DEPTH];

    always_ff @(posedge clock) begin
        if (push0)
            mem_pc[wr_ptr] <= pc;
        if (push1)
            mem_pc[wr_nxt] <= pc;
    end

    assign rd_pc = rd_valid ? mem_pc[rd_ptr] : '0;
`else
    logic unused_pc;
    assign unused_pc = ^pc;
    assign rd_pc     = '0;
`endif

    always_comb begin
        rd_valid = (count != '0);
        rd_kind  = rd_valid & mem_kind[rd_ptr];
        rd_addr  = rd_valid ? mem_addr[rd_ptr]  : '0;
        rd_data  = rd_valid ? mem_data[rd_ptr]  : '0;
        rd_stamp = rd_valid ? mem_stamp[rd_ptr] : '0;
    end
endmodule

// File: tb/tb_wb_trace_monitor.sv
// Directed self-checking bench for wb_trace_monitor (default, DEPTH=4 drop/wrap, CYCLE_LIMIT=10).
module tb_wb_trace_monitor;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc = '0;
    logic        ctrl_writeEnable = 1'b0;
    logic [4:0]  ctrl_writeReg = '0;
    logic [31:0] data_writeReg = '0;
    logic        wren = 1'b0;
    logic [11:0] address_dmem = '0;
    logic [31:0] data = '0;
    logic        rdy_d = 1'b0, rdy_w0 = 1'b0, rdy_w1 = 1'b0, rdy_l = 1'b0;

    logic        d_valid, d_kind, d_done, d_ovf;
    logic [11:0] d_addr;
    logic [31:0] d_data, d_pc;
    logic [15:0] d_stamp;
    logic [4:0]  d_count;

    logic        w0_valid, w0_kind, w0_done, w0_ovf;
    logic [11:0] w0_addr;
    logic [31:0] w0_data, w0_pc;
    logic [15:0] w0_stamp;
    logic [2:0]  w0_count;

    logic        w1_valid, w1_kind, w1_done, w1_ovf;
    logic [11:0] w1_addr;
    logic [31:0] w1_data, w1_pc;
    logic [15:0] w1_stamp;
    logic [2:0]  w1_count;

    logic        l_valid, l_kind, l_done, l_ovf;
    logic [11:0] l_addr;
    logic [31:0] l_data, l_pc;
    logic [15:0] l_stamp;
    logic [4:0]  l_count;

    int checks = 0;
    int fails  = 0;

    always #5 clock = ~clock;

    wb_trace_monitor dut (
        .clock(clock), .reset(reset), .pc(pc),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .wren(wren), .address_dmem(address_dmem),
        .data(data), .rd_ready(rdy_d), .rd_valid(d_valid), .rd_kind(d_kind),
        .rd_addr(d_addr), .rd_data(d_data), .rd_stamp(d_stamp), .rd_pc(d_pc),
        .count(d_count), .done(d_done), .overflow(d_ovf)
    );

    wb_trace_monitor #(.DEPTH(4), .WRAP(0)) dut_w0 (
        .clock(clock), .reset(reset), .pc(pc),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .wren(wren), .address_dmem(address_dmem),
        .data(data), .rd_ready(rdy_w0), .rd_valid(w0_valid), .rd_kind(w0_kind),
        .rd_addr(w0_addr), .rd_data(w0_data), .rd_stamp(w0_stamp), .rd_pc(w0_pc),
        .count(w0_count), .done(w0_done), .overflow(w0_ovf)
    );

    wb_trace_monitor #(.DEPTH(4), .WRAP(1)) dut_w1 (
        .clock(clock), .reset(reset), .pc(pc),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .wren(wren), .address_dmem(address_dmem),
        .data(data), .rd_ready(rdy_w1), .rd_valid(w1_valid), .rd_kind(w1_kind),
        .rd_addr(w1_addr), .rd_data(w1_data), .rd_stamp(w1_stamp), .rd_pc(w1_pc),
        .count(w1_count), .done(w1_done), .overflow(w1_ovf)
    );

    wb_trace_monitor #(.CYCLE_LIMIT(10)) dut_lim (
        .clock(clock), .reset(reset), .pc(pc),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .wren(wren), .address_dmem(address_dmem),
        .data(data), .rd_ready(rdy_l), .rd_valid(l_valid), .rd_kind(l_kind),
        .rd_addr(l_addr), .rd_data(l_data), .rd_stamp(l_stamp), .rd_pc(l_pc),
        .count(l_count), .done(l_done), .overflow(l_ovf)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        wren             = 1'b0;
        address_dmem     = '0;
        data             = '0;
    endtask

    // Leaves time just after an edge; the next rising edge is capture edge 0.
    task automatic do_reset();
        idle();
        rdy_d = 1'b0; rdy_w0 = 1'b0; rdy_w1 = 1'b0; rdy_l = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic reg_write(input int r, input int v);
        ctrl_writeEnable = 1'b1;
        ctrl_writeReg    = 5'(r);
        data_writeReg    = 32'(v);
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (d_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", d_valid); end
        checks++; if (d_count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", d_count); end
        checks++; if (d_done !== 1'b0 || d_ovf !== 1'b0) begin fails++; $display("FAIL reset_flags: got done=%b ovf=%b want 0 0", d_done, d_ovf); end
        checks++; if ({d_kind, d_addr, d_data, d_stamp, d_pc} !== '0) begin fails++; $display("FAIL reset_rd_zero: got addr=%h data=%h stamp=%h pc=%h want 0", d_addr, d_data, d_stamp, d_pc); end
        for (int i = 0; i < 3; i++) begin
            reg_write(i + 1, 16 + i);
            step();
        end
        idle();
        checks++; if (d_count !== 5'd3) begin fails++; $display("FAIL pre_reset_count: got %0d want 3", d_count); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (d_count !== 5'd0 || d_valid !== 1'b0) begin fails++; $display("FAIL midrun_reset: got count=%0d valid=%b want 0 0", d_count, d_valid); end
        checks++; if (d_done !== 1'b0 || d_ovf !== 1'b0) begin fails++; $display("FAIL midrun_flags: got done=%b ovf=%b want 0 0", d_done, d_ovf); end
        reg_write(9, 32'h55);
        step();
        idle();
        checks++; if (d_valid !== 1'b1 || d_stamp !== 16'd0 || d_data !== 32'h55) begin fails++; $display("FAIL post_reset_stamp: got valid=%b stamp=%0d data=%h want 1 0 55", d_valid, d_stamp, d_data); end
    endtask

    task automatic test_reg_write();
        do_reset();
        step();
        step();
        reg_write(5, 32'h1234);
        step();
        checks++; if (d_count !== 5'd1 || d_valid !== 1'b1) begin fails++; $display("FAIL reg_latency: got count=%0d valid=%b want 1 1", d_count, d_valid); end
        reg_write(0, 32'hFFFF);
        step();
        idle();
        checks++; if (d_count !== 5'd1) begin fails++; $display("FAIL r0_ignored: got count=%0d want 1", d_count); end
        checks++; if (d_kind !== 1'b0 || d_addr !== 12'd5) begin fails++; $display("FAIL reg_head: got kind=%b addr=%h want 0 005", d_kind, d_addr); end
        checks++; if (d_data !== 32'h1234 || d_stamp !== 16'd2) begin fails++; $display("FAIL reg_head_val: got data=%h stamp=%0d want 1234 2", d_data, d_stamp); end
        rdy_d = 1'b1;
        step();
        rdy_d = 1'b0;
        checks++; if (d_count !== 5'd0 || d_valid !== 1'b0 || d_data !== 32'd0) begin fails++; $display("FAIL reg_pop_empty: got count=%0d valid=%b data=%h want 0 0 0", d_count, d_valid, d_data); end
    endtask

    task automatic test_dual();
        do_reset();
        for (int i = 0; i < 4; i++) step();
        reg_write(7, 32'hA);
        wren = 1'b1; address_dmem = 12'h010; data = 32'hB;
        step();
        idle();
        checks++; if (d_count !== 5'd2) begin fails++; $display("FAIL dual_count: got %0d want 2", d_count); end
        checks++; if (d_kind !== 1'b0 || d_addr !== 12'd7 || d_data !== 32'hA || d_stamp !== 16'd4) begin fails++; $display("FAIL dual_first: got kind=%b addr=%h data=%h stamp=%0d want 0 007 a 4", d_kind, d_addr, d_data, d_stamp); end
        rdy_d = 1'b1;
        step();
        checks++; if (d_count !== 5'd1) begin fails++; $display("FAIL dual_count_pop: got %0d want 1", d_count); end
        checks++; if (d_kind !== 1'b1 || d_addr !== 12'h010 || d_data !== 32'hB || d_stamp !== 16'd4) begin fails++; $display("FAIL dual_second: got kind=%b addr=%h data=%h stamp=%0d want 1 010 b 4", d_kind, d_addr, d_data, d_stamp); end
        step();
        rdy_d = 1'b0;
        checks++; if (d_count !== 5'd0 || d_valid !== 1'b0) begin fails++; $display("FAIL dual_drained: got count=%0d valid=%b want 0 0", d_count, d_valid); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            reg_write(i + 1, i + 1);
            step();
            if (i == 3) begin
                checks++; if (w0_count !== 3'd4 || w0_ovf !== 1'b0) begin fails++; $display("FAIL full_no_ovf: got count=%0d ovf=%b want 4 0", w0_count, w0_ovf); end
            end
        end
        idle();
        checks++; if (w0_count !== 3'd4 || w0_ovf !== 1'b1) begin fails++; $display("FAIL drop_state: got count=%0d ovf=%b want 4 1", w0_count, w0_ovf); end
        checks++; if (w1_count !== 3'd4 || w1_ovf !== 1'b1) begin fails++; $display("FAIL wrap_state: got count=%0d ovf=%b want 4 1", w1_count, w1_ovf); end
        rdy_w0 = 1'b1;
        rdy_w1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (w0_valid !== 1'b1 || w0_data !== 32'(i + 1) || w0_addr !== 12'(i + 1)) begin fails++; $display("FAIL drop_entry%0d: got valid=%b data=%0d addr=%0d want 1 %0d %0d", i, w0_valid, w0_data, w0_addr, i + 1, i + 1); end
            checks++; if (w1_valid !== 1'b1 || w1_data !== 32'(i + 3) || w1_stamp !== 16'(i + 2)) begin fails++; $display("FAIL wrap_entry%0d: got valid=%b data=%0d stamp=%0d want 1 %0d %0d", i, w1_valid, w1_data, w1_stamp, i + 3, i + 2); end
            step();
        end
        checks++; if (w0_count !== 3'd0 || w1_count !== 3'd0) begin fails++; $display("FAIL ovf_drained: got w0=%0d w1=%0d want 0 0", w0_count, w1_count); end
        checks++; if (w0_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", w0_ovf); end
        do_reset();
        checks++; if (w0_ovf !== 1'b0 || w1_ovf !== 1'b0) begin fails++; $display("FAIL ovf_reset: got w0=%b w1=%b want 0 0", w0_ovf, w1_ovf); end
    endtask

    task automatic test_limit();
        do_reset();
        rdy_l = 1'b1;
        for (int i = 0; i < 13; i++) begin
            reg_write(3, 100 + i);
            step();
            if (i < 10) begin
                checks++; if (l_valid !== 1'b1 || l_stamp !== 16'(i) || l_data !== 32'(100 + i)) begin fails++; $display("FAIL limit_entry%0d: got valid=%b stamp=%0d data=%0d want 1 %0d %0d", i, l_valid, l_stamp, l_data, i, 100 + i); end
                checks++; if (l_done !== (i == 9)) begin fails++; $display("FAIL limit_done%0d: got %b want %b", i, l_done, (i == 9)); end
            end else begin
                checks++; if (l_count !== 5'd0 || l_done !== 1'b1 || l_valid !== 1'b0) begin fails++; $display("FAIL limit_after%0d: got count=%0d done=%b valid=%b want 0 1 0", i, l_count, l_done, l_valid); end
            end
        end
        idle();
        do_reset();
        checks++; if (l_done !== 1'b0 || l_count !== 5'd0) begin fails++; $display("FAIL limit_reset: got done=%b count=%0d want 0 0", l_done, l_count); end
    endtask

    task automatic test_pc();
        logic [31:0] exp_pc;
`ifdef TRACE_PC_EN
        exp_pc = 32'h20;
`else
        exp_pc = 32'h0;
`endif
        do_reset();
        pc = 32'h20;
        reg_write(4, 1);
        step();
        idle();
        pc = 32'h99;
        checks++; if (d_valid !== 1'b1 || d_pc !== exp_pc) begin fails++; $display("FAIL rd_pc: got valid=%b pc=%h want 1 %h", d_valid, d_pc, exp_pc); end
        rdy_d = 1'b1;
        step();
        rdy_d = 1'b0;
        checks++; if (d_pc !== 32'h0) begin fails++; $display("FAIL rd_pc_empty: got %h want 0", d_pc); end
    endtask

    initial begin
        test_reset();
        test_reg_write();
        test_dual();
        test_overflow();
        test_limit();
        test_pc();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
